// File: rtl/lockstep_sync_unit.sv
// lockstep_sync_unit
// Synchronises NB_CORES core data ports with their memory-side ports.
// Lockstep mode: one request batch at a time. All grants of a batch are
// released together, and all responses of a batch are released together.
// Broadcast mode: one access on channel 0 serves every requesting core.
// Outside lockstep mode the block is a combinational pass-through.
// Optional feature: define LOCKSTEP_TIMEOUT_EN to enable a watchdog. It
// force-releases a stalled phase and sets the sticky err_o flag.
module lockstep_sync_unit #(
  parameter int NB_CORES       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           lockstep_mode_i,
  input  logic                           same_address_i,
  input  logic [NB_CORES-1:0]            req_i,
  output logic [NB_CORES-1:0]            gnt_o,
  output logic [NB_CORES-1:0]            rvalid_o,
  output logic [NB_CORES*DATA_WIDTH-1:0] rdata_o,
  output logic [NB_CORES-1:0]            req_o,
  input  logic [NB_CORES-1:0]            gnt_i,
  input  logic [NB_CORES-1:0]            rvalid_i,
  input  logic [NB_CORES*DATA_WIDTH-1:0] rdata_i,
  output logic                           err_o,
  input  logic                           err_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [NB_CORES-1:0] ZERO_MASK = {NB_CORES{1'b0}};
  localparam logic [NB_CORES-1:0] CH0_MASK  = {{(NB_CORES-1){1'b0}}, 1'b1};

  state_e                state_r, state_nx_s;
  logic [NB_CORES-1:0]   rel_mask_r;   // cores that receive gnt/rvalid
  logic [NB_CORES-1:0]   iss_mask_r;   // channels actually issued to memory
  logic [NB_CORES-1:0]   gnt_seen_r;
  logic [NB_CORES-1:0]   rv_seen_r;
  logic                  bcast_r;
  logic [DATA_WIDTH-1:0] rbuf_r [NB_CORES];

  logic                  start_s;
  logic                  bcast_start_s;
  logic                  gnt_all_s;
  logic                  rsp_all_s;
  logic                  timeout_s;
  logic [NB_CORES-1:0]   iss_start_s;
  logic [NB_CORES-1:0]   iss_cur_s;
  logic [NB_CORES-1:0]   rv_take_s;
  logic [DATA_WIDTH-1:0] ch0_s;
  logic [DATA_WIDTH-1:0] rsel_s [NB_CORES];

  // Batch-start decode and grant/response completion detection
  always_comb begin
    bcast_start_s = same_address_i & req_i[0];
    if (bcast_start_s) begin
      iss_start_s = CH0_MASK;
    end else begin
      iss_start_s = req_i;
    end
    if ((state_r == ST_IDLE) && rst_ni && lockstep_mode_i && (req_i != ZERO_MASK)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
    // In IDLE the batch being opened is not registered yet, so use the live mask.
    if (state_r == ST_IDLE) begin
      iss_cur_s = iss_start_s;
    end else begin
      iss_cur_s = iss_mask_r;
    end
    gnt_all_s = (((gnt_seen_r | gnt_i) & iss_cur_s) == iss_cur_s);
    rsp_all_s = (((rv_seen_r | rvalid_i) & iss_mask_r) == iss_mask_r);
    if ((state_r == ST_REQ) || (state_r == ST_RESP)) begin
      rv_take_s = rvalid_i & iss_mask_r;
    end else begin
      rv_take_s = ZERO_MASK;
    end
  end

  // Per-channel response data: live data in the arrival cycle, otherwise the buffered copy
  always_comb begin
    if (rvalid_i[0] && iss_mask_r[0]) begin
      ch0_s = rdata_i[DATA_WIDTH-1:0];
    end else begin
      ch0_s = rbuf_r[0];
    end
    for (int k = 0; k < NB_CORES; k++) begin
      if (bcast_r) begin
        rsel_s[k] = ch0_s;
      end else if (rvalid_i[k] && iss_mask_r[k]) begin
        rsel_s[k] = rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rsel_s[k] = rbuf_r[k];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nx_s = state_r;
    req_o      = ZERO_MASK;
    gnt_o      = ZERO_MASK;
    rvalid_o   = ZERO_MASK;
    for (int k = 0; k < NB_CORES; k++) begin
      rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rsel_s[k];
    end
    case (state_r)
      ST_IDLE: begin
        if (!lockstep_mode_i || !rst_ni) begin
          req_o    = req_i;
          gnt_o    = gnt_i;
          rvalid_o = rvalid_i;
          rdata_o  = rdata_i;
        end else if (start_s) begin
          req_o = iss_start_s;
          if (gnt_all_s) begin
            gnt_o      = req_i;
            state_nx_s = ST_RESP;
          end else begin
            state_nx_s = ST_REQ;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        req_o = iss_mask_r & ~gnt_seen_r;
        if (gnt_all_s || timeout_s) begin
          gnt_o      = rel_mask_r;
          state_nx_s = ST_RESP;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (rsp_all_s || timeout_s) begin
          rvalid_o   = rel_mask_r;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register and batch masks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      rel_mask_r <= ZERO_MASK;
      iss_mask_r <= ZERO_MASK;
      gnt_seen_r <= ZERO_MASK;
      rv_seen_r  <= ZERO_MASK;
      bcast_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            rel_mask_r <= req_i;
            iss_mask_r <= iss_start_s;
            bcast_r    <= bcast_start_s;
            gnt_seen_r <= gnt_i & iss_start_s;
            rv_seen_r  <= ZERO_MASK;
          end
        end
        ST_REQ: begin
          gnt_seen_r <= gnt_seen_r | (gnt_i & iss_mask_r);
          rv_seen_r  <= rv_seen_r | rv_take_s;
        end
        ST_RESP: begin
          if (state_nx_s == ST_IDLE) begin
            rel_mask_r <= ZERO_MASK;
            iss_mask_r <= ZERO_MASK;
            gnt_seen_r <= ZERO_MASK;
            rv_seen_r  <= ZERO_MASK;
            bcast_r    <= 1'b0;
          end else begin
            rv_seen_r <= rv_seen_r | rv_take_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Response data buffer, captured per channel on accepted rvalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_CORES; k++) begin
        rbuf_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < NB_CORES; k++) begin
        if (rv_take_s[k]) begin
          rbuf_r[k] <= rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef LOCKSTEP_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_r;
  logic             err_r;

  assign timeout_s = (state_r != ST_IDLE) && (timer_r == TMR_W'(TIMEOUT_CYCLES));
  assign err_o     = err_r;

  // Phase watchdog: restarts on every phase change, counts while a phase is open
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_r <= {TMR_W{1'b0}};
    end else if ((state_r == ST_IDLE) || (state_nx_s != state_r)) begin
      timer_r <= {TMR_W{1'b0}};
    end else begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end

  // Sticky error flag; a new timeout takes priority over a clear request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else if (err_clr_i) begin
      err_r <= 1'b0;
    end
  end
`else
  logic unused_s;

  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
  assign unused_s  = err_clr_i | (TIMEOUT_CYCLES == 32'sd0);
`endif

endmodule

// File: tb/tb_lockstep_sync_unit.sv
// Testbench for lockstep_sync_unit (NB_CORES=8, DATA_WIDTH=32, TIMEOUT_CYCLES=4).
// Stimulus pushes expected gnt/rvalid events (cycle, masks, data) into a queue;
// a monitor pops one entry each cycle the DUT shows a nonzero gnt_o or rvalid_o.
module tb_lockstep_sync_unit;
  localparam int NB = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [NB-1:0]    gnt;
    logic [NB-1:0]    rv;
    logic [NB-1:0]    dmask;
    logic [NB*DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             lockstep_mode;
  logic             same_address;
  logic             err_clr;
  logic [NB-1:0]    req_i, gnt_o, rvalid_o, req_o, gnt_i, rvalid_i;
  logic [NB*DW-1:0] rdata_o, rdata_i;
  logic             err_o;

  exp_t             exp_q[$];
  int               total = 0;
  int               bad   = 0;
  int               cyc   = 0;
  logic [NB*DW-1:0] d;

  lockstep_sync_unit #(
    .NB_CORES(NB), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .lockstep_mode_i(lockstep_mode),
    .same_address_i(same_address), .req_i(req_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .req_o(req_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_o(err_o), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [NB-1:0] g, input logic [NB-1:0] rv,
                           input logic [NB-1:0] dm, input logic [NB*DW-1:0] dat);
    exp_t e;
    e.cyc = c; e.gnt = g; e.rv = rv; e.dmask = dm; e.data = dat;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every nonzero gnt_o/rvalid_o cycle must match the next queued event
  always @(negedge clk) begin : mon
    exp_t e;
    logic ok;
    if ((gnt_o | rvalid_o) != 8'h00) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d gnt_o=%h rvalid_o=%h expected none", cyc, gnt_o, rvalid_o);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.cyc == cyc) && (gnt_o === e.gnt) && (rvalid_o === e.rv);
        for (int k = 0; k < NB; k++) begin
          if (e.dmask[k] && (rdata_o[k*DW +: DW] !== e.data[k*DW +: DW])) ok = 1'b0;
        end
        if (!ok) begin
          bad++;
          $display("FAIL event: got cyc=%0d gnt=%h rv=%h rdata=%h expected cyc=%0d gnt=%h rv=%h dmask=%h rdata=%h",
                   cyc, gnt_o, rvalid_o, rdata_o, e.cyc, e.gnt, e.rv, e.dmask, e.data);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; lockstep_mode = 1'b0; same_address = 1'b0; err_clr = 1'b0;
    req_i = 8'h00; gnt_i = 8'h00; rvalid_i = 8'h00; rdata_i = '0;
    step; step;
    check("rst_err", {31'd0, err_o}, 32'h0);
    check("rst_req_o", {24'd0, req_o}, 32'h0);
    step;
    rst_ni = 1'b1;
    step;

    // Pass-through
    req_i = 8'h05; gnt_i = 8'h05;
    expect_ev(cyc, 8'h05, 8'h00, 8'h00, '0);
    #1 check("pt_req_o", {24'd0, req_o}, 32'h05);
    step;
    req_i = 8'h00; gnt_i = 8'h00; rvalid_i = 8'h04;
    rdata_i = '0; rdata_i[2*DW +: DW] = 32'hCAFE;
    d = '0; d[2*DW +: DW] = 32'hCAFE;
    expect_ev(cyc, 8'h00, 8'h04, 8'h04, d);
    step;
    rvalid_i = 8'h00; rdata_i = '0;

    // Staggered grants and responses
    lockstep_mode = 1'b1; req_i = 8'hFF; gnt_i = 8'h0F;
    #1 check("stg_req_c0", {24'd0, req_o}, 32'hFF);
    step;
    gnt_i = 8'h00; rvalid_i = 8'h0F;
    for (int k = 0; k < NB; k++) rdata_i[k*DW +: DW] = 32'h100 + k;
    #1 check("stg_req_c1", {24'd0, req_o}, 32'hF0);
    step;
    rvalid_i = 8'h00; gnt_i = 8'hF0; rdata_i = '0;
    expect_ev(cyc, 8'hFF, 8'h00, 8'h00, '0);
    #1 check("stg_req_c2", {24'd0, req_o}, 32'hF0);
    step;
    gnt_i = 8'h00; req_i = 8'h00; rvalid_i = 8'hF0;
    for (int k = 0; k < NB; k++) begin
      rdata_i[k*DW +: DW] = (k < 4) ? 32'hDEAD : 32'h100 + k;
      d[k*DW +: DW] = 32'h100 + k;
    end
    expect_ev(cyc, 8'h00, 8'hFF, 8'hFF, d);
    #1 check("stg_req_resp", {24'd0, req_o}, 32'h00);
    step;
    rvalid_i = 8'h00; rdata_i = '0;

    // Broadcast
    req_i = 8'hFF; same_address = 1'b1; gnt_i = 8'h01;
    expect_ev(cyc, 8'hFF, 8'h00, 8'h00, '0);
    #1 check("bc_req_o", {24'd0, req_o}, 32'h01);
    step;
    req_i = 8'h00; same_address = 1'b0; gnt_i = 8'h00; rvalid_i = 8'h01;
    rdata_i = {8{32'h5555}}; rdata_i[DW-1:0] = 32'h1234;
    d = {8{32'h1234}};
    expect_ev(cyc, 8'h00, 8'hFF, 8'hFF, d);
    step;

    // Back-to-back batch; rvalid outside the issue mask is dropped
    rvalid_i = 8'h00; rdata_i = '0; req_i = 8'h03; gnt_i = 8'h03;
    expect_ev(cyc, 8'h03, 8'h00, 8'h00, '0);
    step;
    req_i = 8'h00; gnt_i = 8'h00; rvalid_i = 8'h83;
    rdata_i[0 +: DW] = 32'hA0; rdata_i[DW +: DW] = 32'hA1; rdata_i[7*DW +: DW] = 32'hEE;
    d = '0; d[0 +: DW] = 32'hA0; d[DW +: DW] = 32'hA1;
    expect_ev(cyc, 8'h00, 8'h03, 8'h03, d);
    step;

    // same_address with req_i[0]=0: no broadcast
    rvalid_i = 8'h00; rdata_i = '0; req_i = 8'h06; same_address = 1'b1; gnt_i = 8'h06;
    expect_ev(cyc, 8'h06, 8'h00, 8'h00, '0);
    #1 check("nobc_req_o", {24'd0, req_o}, 32'h06);
    step;
    req_i = 8'h00; same_address = 1'b0; gnt_i = 8'h00; rvalid_i = 8'h06;
    rdata_i[DW +: DW] = 32'h11; rdata_i[2*DW +: DW] = 32'h22;
    d = '0; d[DW +: DW] = 32'h11; d[2*DW +: DW] = 32'h22;
    expect_ev(cyc, 8'h00, 8'h06, 8'h06, d);
    step;
    rvalid_i = 8'h00; rdata_i = '0;

`ifdef LOCKSTEP_TIMEOUT_EN
    // Watchdog: only gnt_i[0] arrives; forced release 4 cycles after REQ entry
    req_i = 8'h03; gnt_i = 8'h01;
    expect_ev(cyc + 5, 8'h03, 8'h00, 8'h00, '0);
    #1 check("to_req_c0", {24'd0, req_o}, 32'h03);
    step;
    gnt_i = 8'h00;
    #1 check("to_req_c1", {24'd0, req_o}, 32'h02);
    repeat (3) step;
    check("to_err_before", {31'd0, err_o}, 32'h0);
    step;
    step;
    req_i = 8'h00; rvalid_i = 8'h03;
    rdata_i[0 +: DW] = 32'h77; rdata_i[DW +: DW] = 32'h88;
    d = '0; d[0 +: DW] = 32'h77; d[DW +: DW] = 32'h88;
    expect_ev(cyc, 8'h00, 8'h03, 8'h03, d);
    check("to_err_set", {31'd0, err_o}, 32'h1);
    step;
    rvalid_i = 8'h00; rdata_i = '0;
    check("to_err_sticky", {31'd0, err_o}, 32'h1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    check("to_err_cleared", {31'd0, err_o}, 32'h0);
`else
    // No watchdog: a stalled grant phase simply waits
    req_i = 8'h03; gnt_i = 8'h01;
    step;
    gnt_i = 8'h00;
    repeat (6) step;
    gnt_i = 8'h02;
    expect_ev(cyc, 8'h03, 8'h00, 8'h00, '0);
    step;
    req_i = 8'h00; gnt_i = 8'h00; rvalid_i = 8'h03;
    rdata_i[0 +: DW] = 32'h77; rdata_i[DW +: DW] = 32'h88;
    d = '0; d[0 +: DW] = 32'h77; d[DW +: DW] = 32'h88;
    expect_ev(cyc, 8'h00, 8'h03, 8'h03, d);
    err_clr = 1'b1;
    step;
    rvalid_i = 8'h00; rdata_i = '0; err_clr = 1'b0;
    check("noto_err", {31'd0, err_o}, 32'h0);
`endif

    // Reset in the middle of the response phase
    req_i = 8'h03; gnt_i = 8'h03;
    expect_ev(cyc, 8'h03, 8'h00, 8'h00, '0);
    step;
    req_i = 8'h00; gnt_i = 8'h00; rvalid_i = 8'h01; rdata_i[0 +: DW] = 32'h99;
    step;
    rvalid_i = 8'h00; rst_ni = 1'b0; req_i = 8'h05;
    #1 check("rst_mid_err", {31'd0, err_o}, 32'h0);
    check("rst_mid_passthru", {24'd0, req_o}, 32'h05);
    step;
    req_i = 8'h00;
    step;
    rst_ni = 1'b1;
    step;
    // Lockstep IDLE drops a stray rvalid
    rvalid_i = 8'h02;
    step;
    // Fresh batch: channel 0 must not inherit the aborted response
    rvalid_i = 8'h00; req_i = 8'h03; gnt_i = 8'h03;
    expect_ev(cyc, 8'h03, 8'h00, 8'h00, '0);
    step;
    req_i = 8'h00; gnt_i = 8'h00; rvalid_i = 8'h02; rdata_i[DW +: DW] = 32'h42;
    step;
    rvalid_i = 8'h01; rdata_i[0 +: DW] = 32'h41; rdata_i[DW +: DW] = 32'hBAD;
    d = '0; d[0 +: DW] = 32'h41; d[DW +: DW] = 32'h42;
    expect_ev(cyc, 8'h00, 8'h03, 8'h03, d);
    step;
    rvalid_i = 8'h00; rdata_i = '0; lockstep_mode = 1'b0;
    repeat (3) step;
    check("pending_events", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
